// File: rtl/input_buffer_pingpong_if.sv
// Sample-stream, bank-read and status signals of the ping-pong input buffer.
// Define INBUF_DROP_COUNT_EN to add the saturating drop_count output.
interface input_buffer_pingpong_if #(
  parameter int BLOCK_SIZE = 256,
  parameter int DATA_WIDTH = 16
);
  localparam int ADDR_WIDTH = $clog2(BLOCK_SIZE);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  block_release;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ready_for_processing;
  logic [1:0]            blocks_pending;
  logic                  overflow;
  logic                  overflow_clr;
`ifdef INBUF_DROP_COUNT_EN
  logic [15:0]           drop_count;

  modport master (
    output in_valid, in_data, block_release, rd_addr, overflow_clr,
    input  rd_data, ready_for_processing, blocks_pending, overflow, drop_count
  );
  modport slave (
    input  in_valid, in_data, block_release, rd_addr, overflow_clr,
    output rd_data, ready_for_processing, blocks_pending, overflow, drop_count
  );
`else
  modport master (
    output in_valid, in_data, block_release, rd_addr, overflow_clr,
    input  rd_data, ready_for_processing, blocks_pending, overflow
  );
  modport slave (
    input  in_valid, in_data, block_release, rd_addr, overflow_clr,
    output rd_data, ready_for_processing, blocks_pending, overflow
  );
`endif
endinterface

// File: rtl/input_buffer_pingpong.sv
// Double-banked capture buffer: fills BLOCK_SIZE-sample blocks alternately, serves reads of the ready bank.
// Optional INBUF_DROP_COUNT_EN adds a 16-bit saturating dropped-sample counter.
module input_buffer_pingpong #(
  parameter int BLOCK_SIZE = 256,
  parameter int DATA_WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  input_buffer_pingpong_if.slave io
);
  localparam int ADDR_WIDTH = $clog2(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic {FILL, STALL} wr_state_e;

  logic [DATA_WIDTH-1:0] r_mem [2][BLOCK_SIZE];
  logic [1:0]            r_bank_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_overflow;
  logic                  r_ready;
  logic [1:0]            r_pending;

  wr_state_e             w_state;
  logic                  w_write;
  logic                  w_drop;
  logic [1:0]            w_bank_full_nxt;
  logic                  w_wr_bank_nxt;
  logic                  w_rd_bank_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
  logic                  w_overflow_nxt;

  // The write state is implied by whether the current write bank still holds an unreleased block.
  always_comb begin
    w_state         = r_bank_full[r_wr_bank] ? STALL : FILL;
    w_write         = 1'b0;
    w_drop          = 1'b0;
    w_bank_full_nxt = r_bank_full;
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_bank_nxt   = r_rd_bank;
    w_wr_ptr_nxt    = r_wr_ptr;

    case (w_state)
      FILL: begin
        if (io.in_valid) begin
          w_write = 1'b1;
          if (r_wr_ptr == LAST_ADDR) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt              = ~r_wr_bank;
            w_wr_ptr_nxt               = '0;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(1);
          end
        end
      end
      STALL: begin
        if (io.in_valid) w_drop = 1'b1;
      end
      default: ;
    endcase

    // Completion can only target the non-full write bank, so it never collides with a release.
    if (io.block_release && r_bank_full[r_rd_bank]) begin
      w_bank_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt              = ~r_rd_bank;
    end

    w_overflow_nxt = io.overflow_clr ? 1'b0 : (r_overflow | w_drop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bank_full <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_ready     <= 1'b0;
      r_pending   <= '0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_overflow  <= w_overflow_nxt;
      r_ready     <= w_bank_full_nxt[w_rd_bank_nxt];
      r_pending   <= {1'b0, w_bank_full_nxt[0]} + {1'b0, w_bank_full_nxt[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_write) r_mem[r_wr_bank][r_wr_ptr] <= io.in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= r_mem[r_rd_bank][io.rd_addr];
  end

`ifdef INBUF_DROP_COUNT_EN
  logic [15:0] r_drop_count;
  logic [15:0] w_drop_count_nxt;

  always_comb begin
    w_drop_count_nxt = r_drop_count;
    if (io.overflow_clr)                     w_drop_count_nxt = '0;
    else if (w_drop && (r_drop_count != '1)) w_drop_count_nxt = r_drop_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_drop_count <= '0;
    else        r_drop_count <= w_drop_count_nxt;
  end

  assign io.drop_count = r_drop_count;
`endif

  assign io.rd_data              = r_rd_data;
  assign io.ready_for_processing = r_ready;
  assign io.blocks_pending       = r_pending;
  assign io.overflow             = r_overflow;
endmodule

// File: doc/input_buffer_pingpong.md
# input_buffer_pingpong

Double-banked sample capture buffer at the front of the DSP accelerator. It accepts a free-running sample stream with no backpressure (ADC/serdes side) and assembles `BLOCK_SIZE`-sample blocks alternately in two banks. It raises `ready_for_processing` to the controller when a complete block is waiting. It also serves random-access reads of that block to the FIR/FFT engines until the controller releases it.

## Interface
- `BLOCK_SIZE`, 256, samples per block; power of two, ≥ 2.
- `DATA_WIDTH`, 16, sample width in bits.
- Derived locally: `ADDR_WIDTH = $clog2(BLOCK_SIZE)`.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on rising `clk`.
- `in_valid`  in  1  sample strobe; one sample per cycle when high.
- `in_data`  in  DATA_WIDTH  sample value.
- `block_release`  in  1  single-cycle pulse from controller: current read bank consumed.
- `rd_addr`  in  ADDR_WIDTH  read index into current read bank.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `ready_for_processing`  out  1  level: read bank holds a complete block.
- `blocks_pending`  out  2  number of full banks (0–2).
- `overflow`  out  1  sticky: at least one sample dropped since reset or clear.
- `overflow_clr`  in  1  clears `overflow` (and the drop counter, if present).

## Operation
- State: `bank_full[1:0]`, `wr_bank`, `rd_bank`, `wr_ptr[ADDR_WIDTH-1:0]`, storage `mem[2][BLOCK_SIZE]`.
- Reset values: `wr_ptr=0`, `wr_bank=0`, `rd_bank=0`, `bank_full=2'b00`, `rd_data=0`, `overflow=0`, `ready_for_processing=0`, `blocks_pending=0`. Memory contents are not reset.
- Write FSM, per cycle with `in_valid=1`:
  - FILL (`bank_full[wr_bank]=0`): write `mem[wr_bank][wr_ptr]` and increment `wr_ptr`. When `wr_ptr==BLOCK_SIZE-1`: set `bank_full[wr_bank]`, toggle `wr_bank`, and wrap `wr_ptr` to 0.
  - STALL (`bank_full[wr_bank]=1`, both banks full): drop the sample and set `overflow`. `wr_ptr` is unchanged, so no partial block is corrupted.
- Release: `block_release=1` while `bank_full[rd_bank]=1` clears `bank_full[rd_bank]` and toggles `rd_bank`. `block_release` while not ready is ignored with no state change.
- Simultaneous block completion and release in the same cycle: both take effect, on different banks. `blocks_pending` is net unchanged.
- Release in the same cycle as a sample arriving in STALL: the sample is still dropped, because the decision uses pre-edge state. The next sample writes the freed bank.
- `ready_for_processing = bank_full[rd_bank]`. `blocks_pending = bank_full[0]+bank_full[1]`. Both are driven from registers only.
- Read: `rd_data <= mem[rd_bank][rd_addr]` every cycle. Reads are legal at any time; the content is meaningful only while ready.
- `overflow_clr` has priority over a same-cycle drop (the result is cleared).
- `reset=0` mid-fill or mid-read returns everything to reset values next edge. The partial block is discarded.

## Timing
- The last sample of a block written at edge N makes `ready_for_processing` high after edge N (visible in cycle N+1).
- `rd_addr` presented in cycle K produces `rd_data` valid in cycle K+1 (1-cycle latency).
- `block_release` at edge M: `rd_bank` switches after M. `ready_for_processing` after M reflects the other bank.
- Sustained throughput is 1 sample/cycle with no drops, provided each block is released within `BLOCK_SIZE` cycles of its completion.

## Configuration
- `INBUF_DROP_COUNT_EN` defined: adds output `drop_count` (16 bits). It increments on every dropped sample, saturates at 16'hFFFF, resets to 0, and clears on `overflow_clr`.
- Not defined: the port and counter are absent. Only the sticky `overflow` flag exists.

## Test plan
- Reset, then 256 consecutive samples 0..255 → `ready_for_processing`=1 the cycle after sample 255 with `blocks_pending`=1. `rd_addr`=5 → `rd_data`=5 the next cycle.
- 512 samples with no release → `blocks_pending`=2. Samples 512–514 are dropped and `overflow`=1 (with the macro, `drop_count`=3). Then release → `rd_bank`=1 and `blocks_pending`=1. The next sample lands at bank 0, addr 0.
- `block_release` pulsed with `blocks_pending`=0 → no change. The next 256 samples still fill bank 0.
- Release on the same edge as bank 1's final sample (bank 0 ready) → `blocks_pending` stays 1, `ready_for_processing` stays 1, and reads return bank 1 data.
- `reset`=0 after 100 samples → all outputs 0. The following 256 samples form a complete block starting at the first post-reset sample.
- `overflow_clr` asserted on the same cycle as a drop → `overflow`=0 (with the macro, `drop_count`=0).
